// File: rtl/perf_pkg.sv
// Shared types, channel map and increment helper for the performance event monitor.
package perf_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_e;

  localparam int CH_INST  = 0;
  localparam int CH_ICHIT = 1;
  localparam int CH_ICREQ = 2;
  localparam int CH_DCHIT = 3;
  localparam int CH_DCREQ = 4;
  localparam int CH_MEMWR = 5;

  localparam int DEF_NUM_CH   = 6;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_SATURATE = 1;
  localparam int DEF_SEL_W    = 4;

  // Next value of a w-bit counter held in the low bits of v; sat selects stick-at-max vs wrap.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic inc,
                                          input int unsigned w, input logic sat);
    logic [63:0] all_ones;
    all_ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (!inc) return v;
    if (v == all_ones) return sat ? all_ones : 64'd0;
    return v + 64'd1;
  endfunction

endpackage

// File: rtl/perf_event_monitor_if.sv
// Control, event and readout bundle between the core-side logic and the event monitor.
interface perf_event_monitor_if #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
);
  logic              en;
  logic              clr;
  logic [NUM_CH-1:0] event_in;
  logic              halt;
  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH:0]   ovf;
  logic              frozen;

  modport master (
    output en, clr, event_in, halt, rd_req, rd_sel,
    input  rd_valid, rd_data, ovf, frozen
  );

  modport slave (
    input  en, clr, event_in, halt, rd_req, rd_sel,
    output rd_valid, rd_data, ovf, frozen
  );
endinterface

// File: rtl/perf_counter.sv
// One event counter with sticky overflow flag; saturating or wrapping by parameter.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [CNT_W-1:0] w_next;

  assign w_next = CNT_W'(sat_inc(64'(r_count), inc, CNT_W, SATURATE != 0));

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (inc) begin
      r_count <= w_next;
      if (&r_count) r_ovf <= 1'b1;
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: rtl/perf_event_monitor.sv
// Event counters plus cycle counter; halt freezes and snapshots them, a registered port reads them out.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = DEF_SATURATE,
  parameter int SEL_W    = DEF_SEL_W
) (
  input logic                 clk,
  input logic                 rst,
  perf_event_monitor_if.slave bus
);

  localparam int NCNT = NUM_CH + 1;

  state_e           r_state;
  logic             r_frozen;
  logic [NCNT-1:0]  w_inc;
  logic [NCNT-1:0]  w_ovf;
  logic [CNT_W-1:0] w_count [NCNT];
  logic [CNT_W-1:0] w_post  [NCNT];
  logic [CNT_W-1:0] r_snap  [NCNT];
  logic             w_freeze;
  logic [CNT_W-1:0] w_rd_mux;
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;

  // Top counter is the free-running cycle counter; all stop outside RUN or when disabled.
  assign w_inc    = (r_state == RUN && bus.en) ? {1'b1, bus.event_in} : '0;
  assign w_freeze = (r_state == RUN) && bus.halt && !bus.clr;

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc[i]),
      .clr   (bus.clr),
      .count (w_count[i]),
      .ovf   (w_ovf[i])
    );
    // Snapshot must include the halt cycle, so it captures the counter's next value.
    assign w_post[i] = CNT_W'(sat_inc(64'(w_count[i]), w_inc[i], CNT_W, SATURATE != 0));
  end

  // NOTE: the snapshot array is reset explicitly; readout must never expose pre-reset contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_frozen <= 1'b0;
      for (int i = 0; i < NCNT; i++) r_snap[i] <= '0;
    end else if (bus.clr) begin
      r_state  <= RUN;
      r_frozen <= 1'b0;
      for (int i = 0; i < NCNT; i++) r_snap[i] <= '0;
    end else if (w_freeze) begin
      r_state  <= FROZEN;
      r_frozen <= 1'b1;
      for (int i = 0; i < NCNT; i++) r_snap[i] <= w_post[i];
    end
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (bus.rd_sel == SEL_W'(i)) w_rd_mux = (r_state == FROZEN) ? r_snap[i] : w_count[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) r_rd_data <= w_rd_mux;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.ovf      = w_ovf;
  assign bus.frozen   = r_frozen;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Drives a 32-bit saturating, 8-bit saturating and 8-bit wrapping monitor with one stimulus stream.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en, clr, halt, rd_req;
  logic [5:0] ev;
  logic [3:0] sel;
  bit         live_chk = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  perf_event_monitor_if #(.NUM_CH(6), .CNT_W(32), .SEL_W(4)) if_a ();
  perf_event_monitor_if #(.NUM_CH(6), .CNT_W(8),  .SEL_W(4)) if_s ();
  perf_event_monitor_if #(.NUM_CH(6), .CNT_W(8),  .SEL_W(4)) if_w ();

  assign if_a.en = en;  assign if_a.clr = clr;  assign if_a.halt = halt;
  assign if_a.event_in = ev;  assign if_a.rd_req = rd_req;  assign if_a.rd_sel = sel;
  assign if_s.en = en;  assign if_s.clr = clr;  assign if_s.halt = halt;
  assign if_s.event_in = ev;  assign if_s.rd_req = rd_req;  assign if_s.rd_sel = sel;
  assign if_w.en = en;  assign if_w.clr = clr;  assign if_w.halt = halt;
  assign if_w.event_in = ev;  assign if_w.rd_req = rd_req;  assign if_w.rd_sel = sel;

  perf_event_monitor #(.NUM_CH(6), .CNT_W(32), .SATURATE(1), .SEL_W(4))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  perf_event_monitor #(.NUM_CH(6), .CNT_W(8), .SATURATE(1), .SEL_W(4))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));
  perf_event_monitor #(.NUM_CH(6), .CNT_W(8), .SATURATE(0), .SEL_W(4))
    dut_w (.clk(clk), .rst(rst), .bus(if_w));

  logic [63:0] d_data   [3];
  logic        d_valid  [3];
  logic        d_frozen [3];
  logic [6:0]  d_ovf    [3];

  assign d_data[0] = 64'(if_a.rd_data);  assign d_valid[0] = if_a.rd_valid;
  assign d_data[1] = 64'(if_s.rd_data);  assign d_valid[1] = if_s.rd_valid;
  assign d_data[2] = 64'(if_w.rd_data);  assign d_valid[2] = if_w.rd_valid;
  assign d_frozen[0] = if_a.frozen;  assign d_ovf[0] = if_a.ovf;
  assign d_frozen[1] = if_s.frozen;  assign d_ovf[1] = if_s.ovf;
  assign d_frozen[2] = if_w.frozen;  assign d_ovf[2] = if_w.ovf;

  // Reference model: exact event totals per configuration, mapped to the visible width on demand.
  int unsigned     cfg_w   [3] = '{32, 8, 8};
  bit              cfg_sat [3] = '{1'b1, 1'b1, 1'b0};
  longint unsigned m_cnt   [3][7];
  longint unsigned m_snap  [3][7];
  longint unsigned m_data  [3];
  bit              m_frz;
  bit              m_valid;

  function automatic longint unsigned lim_of(int k);
    return (64'd1 << cfg_w[k]) - 64'd1;
  endfunction

  function automatic longint unsigned shown(int k, longint unsigned t);
    if (t <= lim_of(k)) return t;
    return cfg_sat[k] ? lim_of(k) : t % (lim_of(k) + 64'd1);
  endfunction

  function automatic logic [6:0] exp_ovf(int k);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = m_cnt[k][i] > lim_of(k);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        m_cnt[k][i]  = 0;
        m_snap[k][i] = 0;
      end
      m_data[k] = 0;
    end
    m_frz   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    int s;
    s = int'(sel);
    if (rd_req) begin
      for (int k = 0; k < 3; k++)
        m_data[k] = (s <= 6) ? shown(k, m_frz ? m_snap[k][s] : m_cnt[k][s]) : 0;
    end
    m_valid = rd_req;
    if (clr) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 7; i++) begin
          m_cnt[k][i]  = 0;
          m_snap[k][i] = 0;
        end
      m_frz = 1'b0;
    end else begin
      if (!m_frz && en) begin
        for (int k = 0; k < 3; k++) begin
          for (int i = 0; i < 6; i++) m_cnt[k][i] += ev[i];
          m_cnt[k][6] += 1;
        end
      end
      if (!m_frz && halt) begin
        m_frz  = 1'b1;
        m_snap = m_cnt;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && live_chk) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cmp_frozen k%0d", k), 64'(d_frozen[k]), 64'(m_frz));
        check($sformatf("cmp_valid k%0d", k), 64'(d_valid[k]), 64'(m_valid));
        if (m_valid) check($sformatf("cmp_data k%0d", k), d_data[k], m_data[k]);
        check($sformatf("cmp_ovf k%0d", k), 64'(d_ovf[k]), 64'(exp_ovf(k)));
      end
    end
  end

  task automatic cyc(input bit e, input bit c, input bit h, input logic [5:0] v,
                     input bit rq, input logic [3:0] s);
    en = e; clr = c; halt = h; ev = v; rd_req = rq; sel = s;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] v;
    model_reset();
    en = 0; clr = 0; halt = 0; ev = '0; rd_req = 0; sel = '0;
    repeat (3) @(negedge clk);
    check("rst_valid",  64'(d_valid[0]),  64'd0);
    check("rst_data",   d_data[0],        64'd0);
    check("rst_frozen", 64'(d_frozen[0]), 64'd0);
    check("rst_ovf",    64'(d_ovf[0]),    64'd0);
    rst = 1'b1;
    live_chk = 1'b1;

    // Idle counting: only the cycle counter moves.
    repeat (10) cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 1, 6);
    check("idle_cyc", d_data[0], 64'd10);
    check("idle_valid", 64'(d_valid[0]), 64'd1);
    cyc(1, 0, 0, '0, 1, 0);
    check("idle_ch0", d_data[0], 64'd0);
    cyc(1, 0, 0, '0, 1, 9);
    check("sel_oob", d_data[0], 64'd0);
    check("sel_oob_valid", 64'(d_valid[0]), 64'd1);

    // Event counting with back-to-back readout.
    cyc(1, 1, 0, '0, 0, 0);
    for (int j = 0; j < 10; j++) begin
      v = '0;
      v[3] = (j % 2 == 0);
      v[1] = (j < 7);
      cyc(1, 0, 0, v, 0, 0);
    end
    cyc(1, 0, 0, '0, 1, 3);
    check("ev_ch3", d_data[0], 64'd5);
    check("ev_ch3_valid", 64'(d_valid[0]), 64'd1);
    cyc(1, 0, 0, '0, 1, 1);
    check("ev_ch1", d_data[0], 64'd7);
    check("ev_ch1_valid", 64'(d_valid[0]), 64'd1);

    // Halt freeze: the halt cycle is counted, later events are not.
    cyc(1, 1, 0, '0, 0, 0);
    repeat (3) cyc(1, 0, 0, 6'b000001, 0, 0);
    cyc(1, 0, 1, 6'b000001, 0, 0);
    check("halt_frozen", 64'(d_frozen[0]), 64'd1);
    cyc(1, 0, 0, 6'b000001, 1, 6);
    check("halt_cyc_early", d_data[0], 64'd4);
    repeat (20) cyc(1, 0, 0, 6'b000001, 0, 0);
    cyc(1, 0, 0, 6'b000001, 1, 0);
    check("halt_ch0", d_data[0], 64'd4);
    cyc(1, 0, 0, 6'b000001, 1, 6);
    check("halt_cyc_late", d_data[0], 64'd4);

    // Overflow: 300 events on channel 2.
    cyc(1, 1, 0, '0, 0, 0);
    repeat (300) cyc(1, 0, 0, 6'b000100, 0, 0);
    cyc(1, 0, 0, '0, 1, 2);
    check("ovf_wide_data", d_data[0], 64'd300);
    check("ovf_sat_data",  d_data[1], 64'hFF);
    check("ovf_wrap_data", d_data[2], 64'h2C);
    check("ovf_wide_flag", 64'(d_ovf[0][2]), 64'd0);
    check("ovf_sat_flag",  64'(d_ovf[1][2]), 64'd1);
    check("ovf_wrap_flag", 64'(d_ovf[2][2]), 64'd1);

    // clr beats halt in the same cycle.
    cyc(1, 1, 1, 6'h3f, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("clrpri_frozen k%0d", k), 64'(d_frozen[k]), 64'd0);
      check($sformatf("clrpri_ovf k%0d", k), 64'(d_ovf[k]), 64'd0);
    end
    for (int s = 0; s < 7; s++) begin
      cyc(0, 0, 0, '0, 1, 4'(s));
      check($sformatf("clrpri_rd%0d", s), d_data[0], 64'd0);
    end

    // Async reset between a request and its answering edge.
    repeat (5) cyc(1, 0, 0, 6'h21, 0, 0);
    cyc(1, 0, 0, '0, 1, 0);
    check("arst_pre_data", d_data[0], 64'd5);
    en = 1; rd_req = 1; sel = 4'd5;
    #2;
    rst = 1'b0;
    live_chk = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("arst_valid k%0d", k), 64'(d_valid[k]), 64'd0);
      check($sformatf("arst_data k%0d", k), d_data[k], 64'd0);
      check($sformatf("arst_ovf k%0d", k), 64'(d_ovf[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    live_chk = 1'b1;
    repeat (3) cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 1, 6);
    check("arst_resume_cyc", d_data[0], 64'd3);
    cyc(1, 0, 0, '0, 1, 5);
    check("arst_resume_ch5", d_data[0], 64'd0);

    // Randomised traffic checked every cycle against the model.
    repeat (1500) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
          6'($urandom), $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
